matrix_load: RTL
================

Name: matrix_load

Overview:
- Upstream operand-staging stage for matrix_add.
- Accepts a serial stream of IEEE-754 double elements over a valid/ready handshake: all SIZE*SIZE elements of matrix A, then all of matrix B, each in row-major order.
- Packs them into the flattened op_a/op_b buses matrix_add consumes, issues a one-cycle enable, then holds the operands until matrix_add signals ready or a timeout expires.

Parameters:
SIZE, 2, matrix dimension (SIZE x SIZE)
WIDTH, 64, element width in bits (IEEE-754 double)
TIMEOUT, 1024, max cycles waited for add_ready before abandoning the operation

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_data  input  WIDTH  element value
in_valid  input  1  in_data valid
in_ready  output  1  block can accept an element this cycle
op_a  output  SIZE*SIZE*WIDTH  flattened matrix A to matrix_add
op_b  output  SIZE*SIZE*WIDTH  flattened matrix B to matrix_add
enable  output  1  one-cycle start pulse to matrix_add
add_ready  input  1  matrix_add ready (result valid)
busy  output  1  high from first accepted element until return to LOAD_A
timeout  output  1  one-cycle pulse when TIMEOUT expires

Behaviour:
- Reset is asynchronous on rst low and overrides everything, including mid-load or mid-wait.
  - Reset values: op_a=0, op_b=0, enable=0, in_ready=0, busy=0, timeout=0.
  - State returns to LOAD_A, element counter=0, wait counter=0, add_ready history=0.
  - in_ready rises in the first cycle after rst is deasserted.
- Element index k = row*SIZE+col, range 0..SIZE*SIZE-1.
  - Element k occupies bits [k*WIDTH +: WIDTH].
  - a_11 is in [63:0]; for SIZE=2, a_22 is in [255:192].
- An element transfer occurs on a rising edge with in_valid && in_ready.
- No data transformation; bits are copied verbatim, including denormals, NaNs and signed zeros.
- States:
  - LOAD_A: in_ready=1. Each transfer writes op_a slot k and increments k. On the transfer with k=SIZE*SIZE-1: k<=0, go to LOAD_B.
  - LOAD_B: same as LOAD_A, writing op_b. The last transfer goes to FIRE.
  - FIRE: in_ready=0, enable=1 for exactly this one cycle. Clears the wait counter. Go to WAIT.
  - WAIT: in_ready=0, enable=0.
    - A rising edge of add_ready (sampled high this cycle, low the previous cycle, history registered every cycle) goes to LOAD_A.
    - A level-high add_ready left over from the previous operation is not accepted.
    - Otherwise the wait counter increments. When it reaches TIMEOUT-1 without an edge: timeout=1 for one cycle, go to LOAD_A.
- Operand stability: op_a and op_b are stable from FIRE through WAIT.
  - op_a slots change only on LOAD_A transfers, op_b slots only on LOAD_B transfers.
  - Slots not yet rewritten keep their previous values.
- busy=1 whenever state is not LOAD_A, or state is LOAD_A with k!=0.
- Throughput: one element per cycle while in_valid is held. Stalls (in_valid low) are allowed at any point and change nothing.
- Latency: enable is asserted in the cycle after the final B transfer.
- Minimum total: 2*SIZE*SIZE transfer cycles, +1 FIRE cycle, +wait.
- Counter widths:
  - Element counter: clog2(SIZE*SIZE), minimum 1 bit.
  - Wait counter: clog2(TIMEOUT).
  - No wrap-around beyond these limits.
- add_ready is ignored outside WAIT, but its history register is still updated every cycle.

Test Plan:
- Basic load, SIZE=2: stream A = 0x4075900000000000, 0xC08C380000000000, 0x8000B8157268FDAE, 0xC0444CCCCCCCCCCD, then four B elements, in_valid held high.
  - in_ready high for 8 cycles.
  - op_a[63:0]=0x4075900000000000, op_a[255:192]=0xC0444CCCCCCCCCCD, B packed likewise.
  - enable pulses exactly one cycle, in the cycle after the 8th transfer.
- Completion handshake: in WAIT, hold add_ready=1 from before FIRE, drop it for 3 cycles, then raise it.
  - Stays in WAIT until the raise; in_ready returns the next cycle.
  - op_a/op_b are unchanged throughout.
- Bubbles: insert random in_valid=0 gaps between all 8 elements.
  - Packed values are identical to the no-gap case.
  - enable pulses once.
- Timeout with TIMEOUT=16: add_ready held 0.
  - timeout pulses 16 cycles after FIRE; state returns to LOAD_A; no further enable.
  - A second load then works normally.
- Reset mid-operation: assert rst low after 5 transfers, asynchronously between clock edges.
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a full 8-element load completes correctly with counter k starting at 0.
- Partial overwrite: after a completed operation, load a new A with element values 1..4 (0x3FF0000000000000 etc.).
  - op_b is unchanged until the LOAD_B transfers begin.

Source files
------------

// File: rtl/matrix_load.sv
// matrix_load: packs a serial element stream into matrix_add operands and manages the start/complete handshake
module matrix_load #(
  parameter int SIZE    = 2,
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [SIZE*SIZE*WIDTH-1:0] op_a,
  output logic [SIZE*SIZE*WIDTH-1:0] op_b,
  output logic                       enable,
  input  logic                       add_ready,
  output logic                       busy,
  output logic                       timeout
);
  localparam int N  = SIZE * SIZE;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {LOAD_A, LOAD_B, FIRE, WAIT} state_t;
  state_t state, state_n;
  logic [KW-1:0] k;
  logic [TW-1:0] wcnt;
  logic ar_q, run, xfer, last, rise, expired;
  assign xfer    = in_valid && in_ready;
  assign last    = k == KW'(N - 1);
  assign rise    = add_ready && !ar_q;
  assign expired = wcnt == TW'(TIMEOUT - 1);
  assign busy    = state != LOAD_A || k != '0;
  // next state and per-state outputs; run keeps in_ready low until the first edge after reset
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    enable   = 1'b0;
    timeout  = 1'b0;
    case (state)
      LOAD_A: begin
        in_ready = run;
        if (xfer && last) state_n = LOAD_B;
      end
      LOAD_B: begin
        in_ready = run;
        if (xfer && last) state_n = FIRE;
      end
      FIRE: begin
        enable  = 1'b1;
        state_n = WAIT;
      end
      default: begin
        if (rise) state_n = LOAD_A;
        else if (expired) begin
          timeout = 1'b1;
          state_n = LOAD_A;
        end
      end
    endcase
  end
  // state, counters and add_ready history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD_A;
      k     <= '0;
      wcnt  <= '0;
      ar_q  <= 1'b0;
      run   <= 1'b0;
    end else begin
      state <= state_n;
      ar_q  <= add_ready;
      run   <= 1'b1;
      if (xfer) k <= last ? '0 : k + 1'b1;
      if (state == FIRE) wcnt <= '0;
      else if (state == WAIT && !expired) wcnt <= wcnt + 1'b1;
    end
  end
  // operand slots; each is written only by a transfer in its own load phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a <= '0;
      op_b <= '0;
    end else if (xfer) begin
      if (state == LOAD_A) op_a[k*WIDTH +: WIDTH] <= in_data;
      else op_b[k*WIDTH +: WIDTH] <= in_data;
    end
  end
endmodule
